me_stage: RTL and testbench

- Memory-access stage of the 5-stage LoongArch pipeline, between EX and WB.
- Latches the EX payload on a valid/allow-in handshake.
- Finishes loads: selects the byte, half or word from the synchronous data-SRAM read data and extends it.
- Forwards the result and destination back to ID, propagates syscall/ertn markers to WB, and drops its contents on exception/ertn flush.

---
 rtl/me_stage_pkg.sv | 44 ++++
 rtl/me_load_align.sv | 35 +++
 rtl/me_stage.sv | 117 +++++++++++
 tb/tb_me_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/me_stage_pkg.sv
// Shared definitions for the memory-access (ME) stage: bus sizes,
// field positions of the EX->ME and ME->WB buses, and the EX payload struct.
package me_stage_pkg;

    localparam int EX_TO_ME_BUS_SIZE = 78;
    localparam int ME_TO_WB_BUS_SIZE = 71;

    // EX->ME bus field positions (LSB of multi-bit fields)
    localparam int EX_SYSCALL      = 77;
    localparam int EX_ERTN         = 76;
    localparam int EX_SIGNED       = 75;
    localparam int EX_BYTE         = 74;
    localparam int EX_HALF         = 73;
    localparam int EX_OFFSET_LSB   = 71;
    localparam int EX_PC_LSB       = 39;
    localparam int EX_RESULT_LSB   = 7;
    localparam int EX_RES_FROM_MEM = 6;
    localparam int EX_GR_WE        = 5;
    localparam int EX_DEST_LSB     = 0;

    // ME->WB bus field positions. gr_we is folded into the destination
    // field: an instruction that does not write the register file carries
    // dest 0 (r0 writes are discarded anyway), which keeps the bus at 71 bits.
    localparam int WB_SYSCALL      = 70;
    localparam int WB_ERTN         = 69;
    localparam int WB_PC_LSB       = 37;
    localparam int WB_RESULT_LSB   = 5;
    localparam int WB_DEST_FLAG    = 0;

    typedef struct packed {
        logic        syscall;
        logic        ertn;
        logic        ld_signed;
        logic        ld_byte;
        logic        ld_half;
        logic [1:0]  offset;
        logic [31:0] pc;
        logic [31:0] result;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
    } ex_me_bus_t;

endpackage

// File: rtl/me_load_align.sv
// Load data alignment: picks byte/half/word out of the SRAM read word
// and sign- or zero-extends it to 32 bits. Purely combinational.
module me_load_align (
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic        byte_i,
    input  logic        half_i,
    input  logic        signed_i,
    output logic [31:0] load_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed lane and extend it according to the access size
    always_comb begin
        byte_sel    = rdata_i[7:0];
        half_sel    = rdata_i[15:0];
        load_data_o = rdata_i;
        case (offset_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        // offset[0] is irrelevant for halves: misaligned accesses trap in EX
        half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        if (byte_i) begin
            load_data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
        end else if (half_i) begin
            load_data_o = {{16{signed_i & half_sel[15]}}, half_sel};
        end
    end

endmodule

// File: rtl/me_stage.sv
// ME stage of the 5-stage LoongArch pipeline: latches the EX payload,
// finishes loads from the synchronous data SRAM, forwards to ID and
// hands the result to WB. Drops its contents on excp/ertn flush.
// Optional build macro ME_RDATA_HOLD_EN: capture SRAM read data on a WB
// stall so load results survive SRAMs whose output does not persist.
module me_stage
    import me_stage_pkg::*;
#(
    parameter int EX_ME_W = EX_TO_ME_BUS_SIZE,
    parameter int ME_WB_W = ME_TO_WB_BUS_SIZE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               EX_to_ME_Valid,
    input  logic [EX_ME_W-1:0] EX_to_ME_Bus,
    output logic               ME_Allow_in,
    output logic               ME_to_WB_Valid,
    input  logic               WB_Allow_in,
    output logic [ME_WB_W-1:0] ME_to_WB_Bus,
    input  logic [31:0]        data_sram_rdata,
    output logic [4:0]         ME_dest,
    output logic [31:0]        ME_Forward_Res,
    output logic               ME_to_ID_Sys_op,
    input  logic               excp_flush,
    input  logic               ertn_flush
);

    logic        me_valid_q, me_valid_d;
    ex_me_bus_t  payload_q, payload_d;
    logic        flush;
    logic        accept;
    logic [31:0] rdata_sel;
    logic [31:0] load_data;
    logic [31:0] final_result;

    // ME never needs more than one cycle, so ready-go is constant 1
    assign ME_Allow_in = !me_valid_q | WB_Allow_in;
    assign flush       = excp_flush | ertn_flush;
    assign accept      = ME_Allow_in & EX_to_ME_Valid;

    // Next-state for valid bit (flush beats a new arrival) and payload
    always_comb begin
        me_valid_d = me_valid_q;
        payload_d  = payload_q;
        if (flush) begin
            me_valid_d = 1'b0;
        end else if (ME_Allow_in) begin
            me_valid_d = EX_to_ME_Valid;
        end
        // payload is not cleared on flush; the valid bit gates it
        if (accept) begin
            payload_d = ex_me_bus_t'(EX_to_ME_Bus);
        end
    end

    // Stage registers
    always_ff @(posedge clk) begin
        if (reset) begin
            me_valid_q <= 1'b0;
            payload_q  <= '0;
        end else begin
            me_valid_q <= me_valid_d;
            payload_q  <= payload_d;
        end
    end

`ifdef ME_RDATA_HOLD_EN
    logic        held_q, held_d;
    logic [31:0] hold_data_q, hold_data_d;

    // Capture rdata on the first stalled cycle; release on new accept/flush
    always_comb begin
        held_d      = held_q;
        hold_data_d = hold_data_q;
        if (flush || accept) begin
            held_d = 1'b0;
        end else if (me_valid_q && !WB_Allow_in && !held_q) begin
            held_d      = 1'b1;
            hold_data_d = data_sram_rdata;
        end
    end

    // Hold register state
    always_ff @(posedge clk) begin
        if (reset) begin
            held_q      <= 1'b0;
            hold_data_q <= '0;
        end else begin
            held_q      <= held_d;
            hold_data_q <= hold_data_d;
        end
    end

    assign rdata_sel = held_q ? hold_data_q : data_sram_rdata;
`else
    // Live SRAM data only: relies on WB accepting every cycle
    assign rdata_sel = data_sram_rdata;
`endif

    me_load_align u_load_align (
        .rdata_i     (rdata_sel),
        .offset_i    (payload_q.offset),
        .byte_i      (payload_q.ld_byte),
        .half_i      (payload_q.ld_half),
        .signed_i    (payload_q.ld_signed),
        .load_data_o (load_data)
    );

    assign final_result    = payload_q.res_from_mem ? load_data : payload_q.result;
    assign ME_to_WB_Valid  = me_valid_q;
    assign ME_Forward_Res  = final_result;
    assign ME_dest         = payload_q.dest & {5{me_valid_q & payload_q.gr_we}};
    assign ME_to_ID_Sys_op = (payload_q.syscall | payload_q.ertn) & me_valid_q;
    assign ME_to_WB_Bus    = {payload_q.syscall, payload_q.ertn, payload_q.pc,
                              final_result, payload_q.dest & {5{payload_q.gr_we}}};

endmodule

// File: tb/tb_me_stage.sv
// Self-checking bench for me_stage: scoreboard of expected WB bus values
// plus directed checks on forwarding, stalls, flushes and reset.
module tb_me_stage;

    logic        clk;
    logic        reset;
    logic        EX_to_ME_Valid;
    logic [77:0] EX_to_ME_Bus;
    logic        ME_Allow_in;
    logic        ME_to_WB_Valid;
    logic        WB_Allow_in;
    logic [70:0] ME_to_WB_Bus;
    logic [31:0] data_sram_rdata;
    logic [4:0]  ME_dest;
    logic [31:0] ME_Forward_Res;
    logic        ME_to_ID_Sys_op;
    logic        excp_flush;
    logic        ertn_flush;

    int checks = 0;
    int errors = 0;
    logic [70:0] exp_q[$];

    me_stage dut (
        .clk             (clk),
        .reset           (reset),
        .EX_to_ME_Valid  (EX_to_ME_Valid),
        .EX_to_ME_Bus    (EX_to_ME_Bus),
        .ME_Allow_in     (ME_Allow_in),
        .ME_to_WB_Valid  (ME_to_WB_Valid),
        .WB_Allow_in     (WB_Allow_in),
        .ME_to_WB_Bus    (ME_to_WB_Bus),
        .data_sram_rdata (data_sram_rdata),
        .ME_dest         (ME_dest),
        .ME_Forward_Res  (ME_Forward_Res),
        .ME_to_ID_Sys_op (ME_to_ID_Sys_op),
        .excp_flush      (excp_flush),
        .ertn_flush      (ertn_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [77:0] got, input logic [77:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    function automatic logic [77:0] mk_ex(input logic sys, input logic ertn, input logic sgn,
                                          input logic b, input logic h, input logic [1:0] off,
                                          input logic [31:0] pc, input logic [31:0] res,
                                          input logic rfm, input logic we, input logic [4:0] dest);
        return {sys, ertn, sgn, b, h, off, pc, res, rfm, we, dest};
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] r, input logic [1:0] off,
                                               input logic b, input logic h, input logic s);
        logic [31:0] sh;
        logic [7:0]  v8;
        logic [15:0] v16;
        sh  = r >> (int'(off) * 8);
        v8  = sh[7:0];
        v16 = off[1] ? r[31:16] : r[15:0];
        if (b) return s ? {{24{v8[7]}}, v8} : {24'h0, v8};
        if (h) return s ? {{16{v16[15]}}, v16} : {16'h0, v16};
        return r;
    endfunction

    function automatic logic [70:0] exp_wb(input logic [77:0] bus, input logic [31:0] res);
        return {bus[77], bus[76], bus[70:39], res, bus[4:0] & {5{bus[5]}}};
    endfunction

    // Scoreboard: compare every WB handoff against the next expected entry
    always @(negedge clk) begin : wb_monitor
        logic [70:0] e;
        if (!reset && ME_to_WB_Valid && WB_Allow_in) begin
            if (exp_q.size() == 0) begin
                chk("wb_extra", 78'(ME_to_WB_Bus), 78'h0);
            end else begin
                e = exp_q.pop_front();
                chk("wb_bus", 78'(ME_to_WB_Bus), 78'(e));
            end
        end
    end

    // Present one instruction with WB accepting; check forwarding one cycle later
    task automatic send(input string tag, input logic [77:0] bus, input logic [31:0] rdata,
                        input logic [31:0] exp_res);
        @(negedge clk);
        EX_to_ME_Valid = 1'b1;
        EX_to_ME_Bus   = bus;
        @(posedge clk);
        #1;
        EX_to_ME_Valid  = 1'b0;
        data_sram_rdata = rdata;
        exp_q.push_back(exp_wb(bus, exp_res));
        @(negedge clk);
        chk({tag, "_res"},   78'(ME_Forward_Res), 78'(exp_res));
        chk({tag, "_dest"},  78'(ME_dest), 78'(bus[4:0] & {5{bus[5]}}));
        chk({tag, "_sysop"}, 78'(ME_to_ID_Sys_op), 78'(bus[77] | bus[76]));
    endtask

    initial begin : stim
        logic [77:0] bus_a, bus_b, bus_c;
        logic [70:0] wb_a;
        logic [31:0] r, e;
        logic [1:0]  off;
        int          kind;
        logic        sgn;
        int          guard;

        reset = 1'b1; EX_to_ME_Valid = 1'b0; EX_to_ME_Bus = '0; WB_Allow_in = 1'b1;
        data_sram_rdata = '0; excp_flush = 1'b0; ertn_flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", 78'(ME_to_WB_Valid), 78'h0);
        chk("rst_dest",  78'(ME_dest), 78'h0);
        chk("rst_sysop", 78'(ME_to_ID_Sys_op), 78'h0);
        chk("rst_allow", 78'(ME_Allow_in), 78'h1);
        chk("rst_bus",   78'(ME_to_WB_Bus), 78'h0);

        // Directed loads and ALU results
        send("ld_b", mk_ex(0,0,1,1,0,2'd2,32'h1c00_0000,32'h0,1,1,5'd3), 32'h1280_3456, 32'hFFFF_FF80);
        send("ld_hu", mk_ex(0,0,0,0,1,2'd2,32'h1c00_0004,32'h0,1,1,5'd4), 32'hBEEF_1234, 32'h0000_BEEF);
        send("ld_w", mk_ex(0,0,0,0,0,2'd0,32'h1c00_0008,32'h0,1,1,5'd6), 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        send("add", mk_ex(0,0,0,0,0,2'd0,32'h1c00_000c,32'h42,0,1,5'd5), 32'h5555_5555, 32'h0000_0042);
        send("add_nowe", mk_ex(0,0,0,0,0,2'd0,32'h1c00_0010,32'h42,0,0,5'd5), 32'h0, 32'h0000_0042);
        send("sys", mk_ex(1,0,0,0,0,2'd0,32'h1c00_0014,32'h0,0,0,5'd0), 32'h0, 32'h0);
        chk("sys_bit70", 78'(ME_to_WB_Bus[70]), 78'h1);
        send("ertn", mk_ex(0,1,0,0,0,2'd0,32'h1c00_0018,32'h0,0,0,5'd0), 32'h0, 32'h0);

        // Randomised loads against the bench model
        for (int i = 0; i < 8; i++) begin
            r    = $urandom;
            off  = 2'($urandom_range(0, 3));
            kind = $urandom_range(0, 2);
            sgn  = 1'($urandom_range(0, 1));
            e    = model_load(r, off, kind == 0, kind == 1, sgn);
            send("rnd", mk_ex(0,0,sgn,kind==0,kind==1,off,32'h1c00_0100 + 32'(i*4),32'h0,1,1,5'(i+8)), r, e);
        end

        // WB stall: A held for 3 cycles, B waits in EX
        bus_a = mk_ex(0,0,0,0,0,2'd0,32'h1c00_0200,32'h0,1,1,5'd9);
        bus_b = mk_ex(0,0,0,0,0,2'd0,32'h1c00_0204,32'h77,0,1,5'd7);
        wb_a  = exp_wb(bus_a, 32'h1122_3344);
        @(negedge clk);
        WB_Allow_in = 1'b0; EX_to_ME_Valid = 1'b1; EX_to_ME_Bus = bus_a;
        @(posedge clk);
        #1;
        data_sram_rdata = 32'h1122_3344;
        EX_to_ME_Bus    = bus_b;
        exp_q.push_back(wb_a);
        @(negedge clk);
        chk("stall_allow0", 78'(ME_Allow_in), 78'h0);
        chk("stall_bus0",   78'(ME_to_WB_Bus), 78'(wb_a));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
`ifdef ME_RDATA_HOLD_EN
            data_sram_rdata = 32'h0;
`endif
            @(negedge clk);
            chk("stall_allow", 78'(ME_Allow_in), 78'h0);
            chk("stall_bus",   78'(ME_to_WB_Bus), 78'(wb_a));
            chk("stall_valid", 78'(ME_to_WB_Valid), 78'h1);
        end
        @(posedge clk);
        #1 WB_Allow_in = 1'b1;
        @(posedge clk);
        #1;
        EX_to_ME_Valid  = 1'b0;
        data_sram_rdata = 32'h0;
        exp_q.push_back(exp_wb(bus_b, 32'h77));
        @(negedge clk);
        chk("after_stall_res",  78'(ME_Forward_Res), 78'h77);
        chk("after_stall_dest", 78'(ME_dest), 78'h7);

        // excp_flush together with a valid EX instruction: discarded
        @(negedge clk);
        EX_to_ME_Valid = 1'b1;
        EX_to_ME_Bus   = mk_ex(1,0,0,0,0,2'd0,32'h1c00_0300,32'h0,0,1,5'd2);
        excp_flush     = 1'b1;
        @(posedge clk);
        #1;
        EX_to_ME_Valid = 1'b0;
        excp_flush     = 1'b0;
        @(negedge clk);
        chk("flush_valid", 78'(ME_to_WB_Valid), 78'h0);
        chk("flush_dest",  78'(ME_dest), 78'h0);
        chk("flush_sysop", 78'(ME_to_ID_Sys_op), 78'h0);

        // ertn_flush kills a stalled instruction
        bus_c = mk_ex(0,1,0,0,0,2'd0,32'h1c00_0400,32'h5,0,1,5'd11);
        @(negedge clk);
        WB_Allow_in = 1'b0; EX_to_ME_Valid = 1'b1; EX_to_ME_Bus = bus_c;
        @(posedge clk);
        #1 EX_to_ME_Valid = 1'b0;
        @(negedge clk);
        chk("ertn_pre_sysop", 78'(ME_to_ID_Sys_op), 78'h1);
        ertn_flush = 1'b1;
        @(posedge clk);
        #1 ertn_flush = 1'b0;
        @(negedge clk);
        chk("ertn_valid", 78'(ME_to_WB_Valid), 78'h0);
        chk("ertn_allow", 78'(ME_Allow_in), 78'h1);

        // Reset in the middle of a stall
        @(negedge clk);
        EX_to_ME_Valid = 1'b1;
        EX_to_ME_Bus   = mk_ex(1,0,0,0,0,2'd0,32'h1c00_0500,32'hAB,0,1,5'd12);
        @(posedge clk);
        #1 EX_to_ME_Valid = 1'b0;
        @(negedge clk);
        chk("rst2_pre_valid", 78'(ME_to_WB_Valid), 78'h1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst2_valid", 78'(ME_to_WB_Valid), 78'h0);
        chk("rst2_dest",  78'(ME_dest), 78'h0);
        chk("rst2_sysop", 78'(ME_to_ID_Sys_op), 78'h0);
        chk("rst2_allow", 78'(ME_Allow_in), 78'h1);
        chk("rst2_bus",   78'(ME_to_WB_Bus), 78'h0);
        WB_Allow_in = 1'b1;

        // Final load after recovery, then drain the scoreboard
        send("post_rst", mk_ex(0,0,1,0,1,2'd0,32'h1c00_0600,32'h0,1,1,5'd13), 32'h0000_8001, 32'hFFFF_8001);
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        @(negedge clk);
        chk("drain", 78'(exp_q.size()), 78'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
